div_seq: RTL and testbench

Multi-cycle sequencer for the MIPS DIV/DIVU instructions, sitting beside the EX stage. It accepts a start request from EX and runs a 32-iteration restoring division. While it runs, it requests a pipeline stall from the stall controller. When done, it presents the 64-bit {remainder, quotient} pair, which EX forwards into the HI/LO write path (HI = remainder, LO = quotient).

---
 rtl/div_seq_pkg.sv | 14 +
 rtl/div_seq_step.sv | 25 ++
 rtl/div_seq.sv | 137 +++++++++++++
 tb/tb_div_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the DIV/DIVU sequencer.
// The iteration count equals the operand width.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_CALC   = 2'd2,
        DIV_DONE   = 2'd3
    } div_state_t;

    localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration over the {partial remainder, dividend} register.
// Purely combinational so that two instances can be chained per cycle later.
module div_step #(
    parameter int W = 32
) (
    input  logic [2*W:0] rem_i,
    input  logic [W-1:0] divisor_i,
    output logic [2*W:0] rem_o
);

    logic [2*W:0] shifted;
    logic [W+1:0] diff;

    always_comb begin
        shifted = {rem_i[2*W-1:0], 1'b0};
        // Extra top bit makes the trial-difference sign explicit.
        diff    = rem_i[2*W:W-1] - {2'b00, divisor_i};
        if (!diff[W+1]) begin
            rem_o = {diff[W:0], shifted[W-1:1], 1'b1};
        end else begin
            rem_o = shifted;
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer beside EX: W-iteration restoring division,
// stall request while busy, {remainder, quotient} held while o_ready is high.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int W = DIV_CYCLES
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_annul,
    input  logic           i_signed,
    input  logic [W-1:0]   i_dividend,
    input  logic [W-1:0]   i_divisor,
    output logic [2*W-1:0] o_result,
    output logic           o_ready,
    output logic           o_stall_req
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    div_state_t     state_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W:0]   rem_q;
    logic [2*W:0]   rem_d;
    logic [W-1:0]   divisor_q;
    logic           qneg_q;
    logic           rneg_q;
    logic           ready_q;
    logic [2*W-1:0] result_q;

    logic           dividend_neg;
    logic           divisor_neg;
    logic [W-1:0]   dividend_mag;
    logic [W-1:0]   divisor_mag;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;
    logic [2*W-1:0] result_d;

    div_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_d)
    );

    assign dividend_neg = i_signed & i_dividend[W-1];
    assign divisor_neg  = i_signed & i_divisor[W-1];

    always_comb begin
        dividend_mag = dividend_neg ? (~i_dividend + 1'b1) : i_dividend;
        divisor_mag  = divisor_neg  ? (~i_divisor + 1'b1)  : i_divisor;
        // Sign fix is applied to the final iteration's output so it lands in result_q at the DONE edge.
        quot_fix     = qneg_q ? (~rem_d[W-1:0] + 1'b1)   : rem_d[W-1:0];
        rem_fix      = rneg_q ? (~rem_d[2*W-1:W] + 1'b1) : rem_d[2*W-1:W];
        result_d     = {rem_fix, quot_fix};
    end

    always_comb begin
        o_stall_req = 1'b0;
        case (state_q)
            DIV_IDLE:   o_stall_req = i_start & ~i_annul;
            DIV_BYZERO: o_stall_req = 1'b1;
            DIV_CALC:   o_stall_req = 1'b1;
            default:    o_stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (i_start && !i_annul) begin
                        qneg_q <= dividend_neg ^ divisor_neg;
                        rneg_q <= dividend_neg;
                        cnt_q  <= '0;
                        if (i_divisor == '0) begin
                            state_q <= DIV_BYZERO;
                        end else begin
                            state_q   <= DIV_CALC;
                            rem_q     <= {{(W+1){1'b0}}, dividend_mag};
                            divisor_q <= divisor_mag;
                        end
                    end
                end
                DIV_BYZERO: begin
                    if (i_annul) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        state_q  <= DIV_DONE;
                        ready_q  <= 1'b1;
                        result_q <= '0;
                    end
                end
                DIV_CALC: begin
                    if (i_annul) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) begin
                            state_q  <= DIV_DONE;
                            ready_q  <= 1'b1;
                            result_q <= result_d;
                        end
                    end
                end
                DIV_DONE: begin
                    if (i_annul || !i_start) begin
                        state_q  <= DIV_IDLE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = ready_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed bench for div_seq against an integer-arithmetic reference.
module tb_div_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic           sgn = 1'b0;
    logic [W-1:0]   dvd = '0;
    logic [W-1:0]   dsr = '0;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq #(.W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_annul     (annul),
        .i_signed    (sgn),
        .i_dividend  (dvd),
        .i_divisor   (dsr),
        .o_result    (result),
        .o_ready     (ready),
        .o_stall_req (stall)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {remainder, quotient} from plain 64-bit integer division (truncating toward zero).
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'(a);
            nb = longint'(b);
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input string tag);
        logic [63:0] exp;
        int lat;
        bit got;
        exp = ref_div(s, a, b);
        @(negedge clk);
        sgn = s; dvd = a; dsr = b; start = 1'b1;
        #1 check_eq({tag, "_stall_pre"}, 64'(stall), 64'd1);
        @(posedge clk);
        @(negedge clk);
        // Operands must only matter at the start edge.
        dvd = $urandom; dsr = $urandom; sgn = ~sgn;
        lat = 1; got = 0;
        while (!got && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) got = 1;
            else begin
                check_eq({tag, "_stall_busy"}, 64'(stall), 64'd1);
                lat++;
            end
        end
        check_eq({tag, "_latency"}, got ? 64'(lat) : 64'hDEAD, (b == 32'd0) ? 64'd1 : 64'd32);
        check_eq({tag, "_result"}, result, exp);
        check_eq({tag, "_stall_done"}, 64'(stall), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq({tag, "_hold_ready"}, 64'(ready), 64'd1);
            check_eq({tag, "_hold_result"}, result, exp);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_idle_ready"}, 64'(ready), 64'd0);
        check_eq({tag, "_idle_stall"}, 64'(stall), 64'd0);
        $display("div %s s=%0d a=%h b=%h result=%h expected=%h lat=%0d", tag, s, a, b, result, exp, lat);
    endtask

    initial begin
        bit seen;
        logic [31:0] ra, rb;
        bit rs;
        int mode;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 64'(ready), 64'd0);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1, "div_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1, "div_7_m2");
        run_div(1'b1, 32'd5, 32'd0, 1, "div_by_zero");
        run_div(1'b0, 32'hFFFFFFFF, 32'd0, 0, "divu_by_zero");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1, "div_overflow");
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1, "divu_max");
        run_div(1'b0, 32'd100, 32'd7, 5, "hold5");

        // Annul at iteration 10: back to IDLE, no ready pulse.
        @(negedge clk);
        sgn = 1'b0; dvd = 32'd100; dsr = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1 check_eq("annul_stall_calc", 64'(stall), 64'd1);
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        #1 check_eq("annul_stall_after", 64'(stall), 64'd0);
        check_eq("annul_ready_after", 64'(ready), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1;
        end
        check_eq("annul_no_ready", 64'(seen), 64'd0);
        $display("annul at iteration 10 ready_seen=%0d", seen);

        // Annul in IDLE blocks the start.
        @(negedge clk);
        start = 1'b1; annul = 1'b1;
        #1 check_eq("annul_idle_stall", 64'(stall), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("annul_idle_stall2", 64'(stall), 64'd0);
        check_eq("annul_idle_ready", 64'(ready), 64'd0);
        start = 1'b0; annul = 1'b0;
        $display("annul in idle blocked start");

        // Reset mid-CALC discards the operation.
        @(negedge clk);
        sgn = 1'b0; dvd = 32'd100; dsr = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_ready", 64'(ready), 64'd0);
        check_eq("midrst_result", result, 64'd0);
        check_eq("midrst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        $display("reset mid-calc applied");
        run_div(1'b0, 32'd100, 32'd7, 0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom % 2);
            ra = $urandom;
            mode = int'($urandom % 8);
            case (mode)
                0:       rb = 32'd0;
                1:       rb = $urandom % 16;
                2:       rb = 32'hFFFFFFFF;
                3:       rb = 32'h80000000;
                default: rb = $urandom >> ($urandom % 32);
            endcase
            run_div(rs, ra, rb, int'($urandom % 3), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
